// File: rtl/distance_pipe_nd.sv
// distance_pipe_nd: streaming L2-squared / L1 distance over DIM axes,
// one sample per cycle, valid/ready back-pressure, tag/mode carried along.
module distance_pipe_nd #(
   parameter int DIM   = 4,
   parameter int WIDTH = 16,
   parameter int TAG_W = 8,
   localparam int L     = $clog2(DIM),
   localparam int OUT_W = 2*WIDTH + L,
   localparam int LAT   = 2 + L
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 in_valid_in,
   output logic                 in_ready_out,
   input  logic                 mode_in,
   input  logic [TAG_W-1:0]     tag_in,
   input  logic [DIM*WIDTH-1:0] vertex_pos_in,
   input  logic [DIM*WIDTH-1:0] query_pos_in,
   output logic                 out_valid_out,
   input  logic                 out_ready_in,
   output logic [OUT_W-1:0]     distance_out,
   output logic [TAG_W-1:0]     tag_out,
   output logic                 mode_out
);

   logic                 advance;
   logic [LAT-1:0]       vld_q;
   logic [LAT-1:0]       mode_q;
   logic [TAG_W-1:0]     tag_q [LAT];
   logic [DIM*WIDTH-1:0] diff_d;
   logic [DIM*WIDTH-1:0] diff_q;

   assign out_valid_out = vld_q[LAT-1];
   assign advance       = !out_valid_out || out_ready_in;
   assign in_ready_out  = advance;
   assign tag_out       = tag_q[LAT-1];
   assign mode_out      = mode_q[LAT-1];

   // Sideband shift chain: index 0 is stage 1, LAT-1 is the result stage.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld_q  <= '0;
         mode_q <= '0;
         for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
      end else if (advance) begin
         vld_q    <= {vld_q[LAT-2:0], in_valid_in};
         mode_q   <= {mode_q[LAT-2:0], mode_in};
         tag_q[0] <= tag_in;
         for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_abs
      logic [WIDTH-1:0] v;
      logic [WIDTH-1:0] q;
      assign v = vertex_pos_in[i*WIDTH +: WIDTH];
      assign q = query_pos_in[i*WIDTH +: WIDTH];
      assign diff_d[i*WIDTH +: WIDTH] = (v >= q) ? v - q : q - v;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) diff_q <= '0;
      else if (advance) diff_q <= diff_d;
   end

   // Level 0 holds the per-axis terms; level l>0 is one adder-tree level.
   for (genvar l = 0; l <= L; l++) begin : g_lvl
      localparam int N = (DIM + (1 << l) - 1) >> l;
      localparam int W = 2*WIDTH + l;
      logic [N*W-1:0] sum_d;
      logic [N*W-1:0] sum_q;

      if (l == 0) begin : g_sq
         for (genvar i = 0; i < DIM; i++) begin : g_ax
            logic [W-1:0] dx;
            assign dx = {{WIDTH{1'b0}}, diff_q[i*WIDTH +: WIDTH]};
            assign sum_d[i*W +: W] = mode_q[0] ? dx : dx * dx;
         end
      end else begin : g_add
         localparam int NP = (DIM + (1 << (l-1)) - 1) >> (l-1);
         localparam int WP = W - 1;
         for (genvar j = 0; j < N; j++) begin : g_node
            logic [W-1:0] a;
            assign a = {1'b0, g_lvl[l-1].sum_q[2*j*WP +: WP]};
            if (2*j + 1 < NP) begin : g_pair
               assign sum_d[j*W +: W] =
                  a + {1'b0, g_lvl[l-1].sum_q[(2*j+1)*WP +: WP]};
            end else begin : g_odd
               assign sum_d[j*W +: W] = a;
            end
         end
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) sum_q <= '0;
         else if (advance) sum_q <= sum_d;
      end
   end

   assign distance_out = g_lvl[L].sum_q;

endmodule

// File: tb/tb_distance_pipe_nd.sv
// tb_distance_pipe_nd: directed checks on DIM=2/4/1/3 builds of the
// distance pipeline (latency, values, back-pressure, reset).
module tb_distance_pipe_nd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic iv [4];
   logic md [4];
   logic ordy [4];
   logic [7:0] tg [4];
   logic [31:0] v0, q0, v1, q1;
   logic [15:0] v2, q2;
   logic [47:0] v3, q3;

   logic ir0, ir1, ir2, ir3;
   logic ov0, ov1, ov2, ov3;
   logic mo0, mo1, mo2, mo3;
   logic [7:0] to0, to1, to2, to3;
   logic [32:0] d0;
   logic [17:0] d1;
   logic [31:0] d2;
   logic [33:0] d3;

   logic [3:0] ir_v, ov_v, mo_v;
   logic [7:0] to_v [4];
   logic [63:0] d_v [4];

   assign ir_v = {ir3, ir2, ir1, ir0};
   assign ov_v = {ov3, ov2, ov1, ov0};
   assign mo_v = {mo3, mo2, mo1, mo0};
   assign to_v[0] = to0;
   assign to_v[1] = to1;
   assign to_v[2] = to2;
   assign to_v[3] = to3;
   assign d_v[0] = 64'(d0);
   assign d_v[1] = 64'(d1);
   assign d_v[2] = 64'(d2);
   assign d_v[3] = 64'(d3);

   int n_chk = 0;
   int n_pass = 0;

   distance_pipe_nd #(.DIM(2), .WIDTH(16), .TAG_W(8)) u_d2 (
      .clk_in(clk), .rst_n_in(rst_n),
      .in_valid_in(iv[0]), .in_ready_out(ir0),
      .mode_in(md[0]), .tag_in(tg[0]),
      .vertex_pos_in(v0), .query_pos_in(q0),
      .out_valid_out(ov0), .out_ready_in(ordy[0]),
      .distance_out(d0), .tag_out(to0), .mode_out(mo0));

   distance_pipe_nd #(.DIM(4), .WIDTH(8), .TAG_W(8)) u_d4 (
      .clk_in(clk), .rst_n_in(rst_n),
      .in_valid_in(iv[1]), .in_ready_out(ir1),
      .mode_in(md[1]), .tag_in(tg[1]),
      .vertex_pos_in(v1), .query_pos_in(q1),
      .out_valid_out(ov1), .out_ready_in(ordy[1]),
      .distance_out(d1), .tag_out(to1), .mode_out(mo1));

   distance_pipe_nd #(.DIM(1), .WIDTH(16), .TAG_W(8)) u_d1 (
      .clk_in(clk), .rst_n_in(rst_n),
      .in_valid_in(iv[2]), .in_ready_out(ir2),
      .mode_in(md[2]), .tag_in(tg[2]),
      .vertex_pos_in(v2), .query_pos_in(q2),
      .out_valid_out(ov2), .out_ready_in(ordy[2]),
      .distance_out(d2), .tag_out(to2), .mode_out(mo2));

   distance_pipe_nd #(.DIM(3), .WIDTH(16), .TAG_W(8)) u_d3 (
      .clk_in(clk), .rst_n_in(rst_n),
      .in_valid_in(iv[3]), .in_ready_out(ir3),
      .mode_in(md[3]), .tag_in(tg[3]),
      .vertex_pos_in(v3), .query_pos_in(q3),
      .out_valid_out(ov3), .out_ready_in(ordy[3]),
      .distance_out(d3), .tag_out(to3), .mode_out(mo3));

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic drive(input int id, input logic val,
                        input logic [63:0] v, input logic [63:0] q,
                        input logic m, input logic [7:0] t);
      iv[id] = val;
      md[id] = m;
      tg[id] = t;
      case (id)
         0: begin v0 = v[31:0]; q0 = q[31:0]; end
         1: begin v1 = v[31:0]; q1 = q[31:0]; end
         2: begin v2 = v[15:0]; q2 = q[15:0]; end
         default: begin v3 = v[47:0]; q3 = q[47:0]; end
      endcase
   endtask

   // Send one sample (caller sits just after a negedge, out_ready high)
   // and check latency, value, tag, mode and single-cycle valid.
   task automatic one(input string nm, input int id,
                      input logic [63:0] v, input logic [63:0] q,
                      input logic m, input logic [7:0] t,
                      input int lat, input logic [63:0] exp);
      int n;
      drive(id, 1'b1, v, q, m, t);
      #1 check({nm, ".rdy"}, 64'(ir_v[id]), 64'd1);
      @(negedge clk);
      iv[id] = 1'b0;
      n = 1;
      while (!ov_v[id] && n < 12) begin
         @(negedge clk);
         n++;
      end
      check({nm, ".lat"}, 64'(n), 64'(lat));
      check({nm, ".dist"}, d_v[id], exp);
      check({nm, ".tag"}, 64'(to_v[id]), 64'(t));
      check({nm, ".mode"}, 64'(mo_v[id]), 64'(m));
      @(negedge clk);
      check({nm, ".once"}, 64'(ov_v[id]), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iv[i] = 1'b0;
         md[i] = 1'b0;
         ordy[i] = 1'b1;
         tg[i] = 8'h00;
      end
      v0 = '0; q0 = '0; v1 = '0; q1 = '0;
      v2 = '0; q2 = '0; v3 = '0; q3 = '0;

      @(negedge clk);
      @(negedge clk);
      check("rst.ov", 64'(ov_v), 64'd0);
      check("rst.dist", d_v[0], 64'd0);
      check("rst.tag", 64'(to_v[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.rdy", 64'(ir_v), 64'hF);

      one("l2", 0, 64'h0004_0003, 64'h0, 1'b0, 8'h11, 3, 64'd25);
      one("l1", 0, 64'h0004_0003, 64'h0, 1'b1, 8'h12, 3, 64'd7);
      one("abs_l2", 0, 64'h000A_0001, 64'h0006_0004, 1'b0, 8'h13, 3, 64'd25);
      one("abs_l1", 0, 64'h000A_0001, 64'h0006_0004, 1'b1, 8'h14, 3, 64'd7);

      one("max_l2", 1, 64'hFFFF_FFFF, 64'h0, 1'b0, 8'h31, 4, 64'd260100);
      one("max_l1", 1, 64'hFFFF_FFFF, 64'h0, 1'b1, 8'h32, 4, 64'd1020);
      one("max_rev", 1, 64'h0, 64'hFFFF_FFFF, 1'b0, 8'h33, 4, 64'd260100);

      one("d1", 2, 64'd9, 64'd2, 1'b0, 8'h41, 2, 64'd49);
      one("d1_max", 2, 64'hFFFF, 64'h0, 1'b0, 8'h42, 2, 64'hFFFE_0001);
      one("d3_l2", 3, 64'h0003_0002_0001, 64'h0004_0004_0004, 1'b0, 8'h51, 4, 64'd14);
      one("d3_l1", 3, 64'h0003_0002_0001, 64'h0004_0004_0004, 1'b1, 8'h52, 4, 64'd6);

      begin : t_stream
         int unsigned ed [6] = '{14, 10, 54, 18, 126, 26};
         int sent;
         int got;
         logic was_blk;
         logic [63:0] hold_d;
         sent = 0;
         got = 0;
         was_blk = 1'b0;
         hold_d = '0;
         for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            ordy[1] = !(cyc >= 3 && cyc < 8);
            if (sent < 6)
               drive(1, 1'b1,
                     64'({8'(sent+3), 8'(sent+2), 8'(sent+1), 8'(sent)}),
                     64'h0, sent[0], 8'(sent));
            else
               iv[1] = 1'b0;
            #1;
            if (ov_v[1] && !ordy[1]) begin
               check("stream.block", 64'(ir_v[1]), 64'd0);
               if (was_blk) check("stream.hold", d_v[1], hold_d);
               was_blk = 1'b1;
               hold_d = d_v[1];
            end else begin
               was_blk = 1'b0;
            end
            if (ov_v[1] && ordy[1]) begin
               check("stream.tag", 64'(to_v[1]), 64'(got));
               check("stream.dist", d_v[1], 64'(ed[got]));
               check("stream.mode", 64'(mo_v[1]), 64'(got & 1));
               got++;
            end
            if (iv[1] && ir_v[1]) sent++;
            @(negedge clk);
         end
         iv[1] = 1'b0;
         ordy[1] = 1'b1;
         check("stream.sent", 64'(sent), 64'd6);
         check("stream.got", 64'(got), 64'd6);
      end

      begin : t_reset
         int seen;
         ordy[0] = 1'b0;
         drive(0, 1'b1, 64'h0004_0003, 64'h0, 1'b0, 8'h21);
         @(negedge clk);
         drive(0, 1'b1, 64'h0008_0006, 64'h0, 1'b0, 8'h22);
         @(negedge clk);
         iv[0] = 1'b0;
         repeat (2) @(negedge clk);
         check("mid.pre_ov", 64'(ov_v[0]), 64'd1);
         check("mid.pre_dist", d_v[0], 64'd25);
         rst_n = 1'b0;
         #1;
         check("mid.ov", 64'(ov_v[0]), 64'd0);
         check("mid.dist", d_v[0], 64'd0);
         check("mid.tag", 64'(to_v[0]), 64'd0);
         @(negedge clk);
         rst_n = 1'b1;
         ordy[0] = 1'b1;
         seen = 0;
         repeat (8) begin
            @(negedge clk);
            if (ov_v[0]) seen++;
         end
         check("mid.ghost", 64'(seen), 64'd0);
      end

      one("post_rst", 0, 64'h0, 64'h0008_0006, 1'b0, 8'h23, 3, 64'd100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
